// File: rtl/xm_stage.sv
// xm_stage: execute -> memory pipeline boundary.
// Non-branch instructions are resolved into {rd, result, store_data, wren}
// records held in a 2-entry skid FIFO. Taken branches do not enter the FIFO;
// they raise a one-cycle registered redirect pulse instead.
// Optional feature macro: XM_EXCEPTION_EN. When it is defined, an ALU
// overflow on add, sub or addi is rewritten to a write of a cause code into
// r30. When it is undefined, alu_ovf is ignored.
module xm_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_opcode,
    input  logic [4:0]  in_aluop,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_target,
    input  logic [31:0] in_store_data,
    input  logic [31:0] alu_result,
    input  logic        alu_ne,
    input  logic        alu_lt,
    input  logic        alu_ovf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic [31:0] out_result,
    output logic [31:0] out_store_data,
    output logic        out_wren,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;

    // Register that receives the overflow cause code.
    localparam logic [4:0] EXC_RD   = 5'd30;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] result;
        logic [31:0] store_data;
        logic        wren;
    } entry_t;

    // Two storage slots, a write and a read pointer, and an occupancy count.
    entry_t      slot_reg [2];
    logic        wr_ptr_reg;
    logic        rd_ptr_reg;
    logic [1:0]  count_reg;

    logic        redirect_valid_reg;
    logic [31:0] redirect_pc_reg;

    // Decoded view of the incoming instruction.
    logic        is_rtype;
    logic        is_addi;
    logic        is_bne;
    logic        is_blt;
    logic        is_sw;
    logic        is_lw;
    logic        is_branch;
    logic        taken;
    entry_t      entry_next;

    logic        accept;
    logic        push;
    logic        pop;
    entry_t      head;

    // Opcode decode and branch resolution.
    always_comb begin
        is_rtype  = (in_opcode == OP_RTYPE);
        is_addi   = (in_opcode == OP_ADDI);
        is_bne    = (in_opcode == OP_BNE);
        is_blt    = (in_opcode == OP_BLT);
        is_sw     = (in_opcode == OP_SW);
        is_lw     = (in_opcode == OP_LW);
        is_branch = is_bne | is_blt;
        taken     = (is_bne & alu_ne) | (is_blt & alu_lt);
    end

`ifdef XM_EXCEPTION_EN
    // Build the FIFO record, substituting a cause code on arithmetic overflow.
    always_comb begin
        entry_next.rd         = in_rd;
        entry_next.result     = alu_result;
        entry_next.store_data = is_sw ? in_store_data : 32'd0;
        entry_next.wren       = is_rtype | is_addi | is_lw;
        if (alu_ovf) begin
            if (is_rtype && in_aluop == ALU_ADD) begin
                entry_next.rd     = EXC_RD;
                entry_next.result = 32'd1;
                entry_next.wren   = 1'b1;
            end else if (is_addi) begin
                entry_next.rd     = EXC_RD;
                entry_next.result = 32'd2;
                entry_next.wren   = 1'b1;
            end else if (is_rtype && in_aluop == ALU_SUB) begin
                entry_next.rd     = EXC_RD;
                entry_next.result = 32'd3;
                entry_next.wren   = 1'b1;
            end
        end
    end
`else
    // The overflow flag and ALU sub-opcode have no effect without the
    // exception remap; fold them into a constant-zero term so they stay
    // connected without influencing the record.
    logic idle_inputs_zero;
    assign idle_inputs_zero = &{1'b0, alu_ovf, in_aluop, EXC_RD, ALU_ADD, ALU_SUB};

    // Build the FIFO record straight from the ALU outcome.
    always_comb begin
        entry_next.rd         = in_rd;
        entry_next.result     = alu_result;
        entry_next.store_data = is_sw ? in_store_data : 32'd0;
        entry_next.wren       = is_rtype | is_addi | is_lw | idle_inputs_zero;
    end
`endif

    // Handshake: in_ready depends only on registered occupancy, never on out_ready.
    always_comb begin
        in_ready  = (count_reg != 2'd2);
        out_valid = (count_reg != 2'd0);
        accept    = in_valid & in_ready;
        push      = accept & ~is_branch;
        pop       = out_valid & out_ready;
        head      = slot_reg[rd_ptr_reg];
    end

    // Head entry drives the outputs; everything reads zero while empty.
    always_comb begin
        out_rd         = out_valid ? head.rd         : 5'd0;
        out_result     = out_valid ? head.result     : 32'd0;
        out_store_data = out_valid ? head.store_data : 32'd0;
        out_wren       = out_valid ? head.wren       : 1'b0;
        redirect_valid = redirect_valid_reg;
        redirect_pc    = redirect_pc_reg;
    end

    // Slot storage: only the slot under the write pointer is loaded on a push.
    // Contents need no reset because outputs are masked by out_valid.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset && push && (wr_ptr_reg == 1'(i))) begin
                slot_reg[i] <= entry_next;
            end
        end
    end

    // Pointers and occupancy; reset discards any buffered entries.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // One-cycle redirect pulse for each accepted taken branch.
    always_ff @(posedge clock) begin
        if (reset) begin
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= 32'd0;
        end else if (accept && taken) begin
            redirect_valid_reg <= 1'b1;
            redirect_pc_reg    <= in_target;
        end else begin
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= 32'd0;
        end
    end

endmodule

// File: tb/tb_xm_stage.sv
// Testbench for xm_stage: table of single-instruction vectors plus directed
// sequences for backpressure, simultaneous push/pop and mid-operation reset.
module tb_xm_stage;

`ifdef XM_EXCEPTION_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [4:0]  in_aluop;
    logic [4:0]  in_rd;
    logic [31:0] in_target;
    logic [31:0] in_store_data;
    logic [31:0] alu_result;
    logic        alu_ne;
    logic        alu_lt;
    logic        alu_ovf;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_result;
    logic [31:0] out_store_data;
    logic        out_wren;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    xm_stage dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_opcode      (in_opcode),
        .in_aluop       (in_aluop),
        .in_rd          (in_rd),
        .in_target      (in_target),
        .in_store_data  (in_store_data),
        .alu_result     (alu_result),
        .alu_ne         (alu_ne),
        .alu_lt         (alu_lt),
        .alu_ovf        (alu_ovf),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_rd         (out_rd),
        .out_result     (out_result),
        .out_store_data (out_store_data),
        .out_wren       (out_wren),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  aluop;
        logic [4:0]  rd;
        logic [31:0] target;
        logic [31:0] sdata;
        logic [31:0] res;
        logic        ne;
        logic        lt;
        logic        ovf;
        logic        e_valid;
        logic [4:0]  e_rd;
        logic [31:0] e_res;
        logic [31:0] e_sd;
        logic        e_wren;
        logic        e_redir;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] aluop,
                         input logic [4:0] rd, input logic [31:0] tgt, input logic [31:0] sd,
                         input logic [31:0] res, input logic ne, input logic lt, input logic ovf);
        in_valid      = v;
        in_opcode     = op;
        in_aluop      = aluop;
        in_rd         = rd;
        in_target     = tgt;
        in_store_data = sd;
        alu_result    = res;
        alu_ne        = ne;
        alu_lt        = lt;
        alu_ovf       = ovf;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // opcode, aluop, rd, target, store_data, alu_result, ne, lt, ovf,
        // exp: valid, rd, result, store_data, wren, redirect, redirect_pc
        vecs[0]  = '{5'b00000, 5'b00000, 5'd4,  32'h0, 32'h0, 32'h5, 1'b0, 1'b0, 1'b0,
                     1'b1, 5'd4, 32'h5, 32'h0, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{5'b00000, 5'b00000, 5'd7,  32'h0, 32'h0, 32'h8000_0000, 1'b0, 1'b0, 1'b1,
                     1'b1, EN ? 5'd30 : 5'd7, EN ? 32'h1 : 32'h8000_0000, 32'h0, 1'b1, 1'b0, 32'h0};
        vecs[2]  = '{5'b00000, 5'b00001, 5'd9,  32'h0, 32'h0, 32'h7fff_ffff, 1'b0, 1'b0, 1'b1,
                     1'b1, EN ? 5'd30 : 5'd9, EN ? 32'h3 : 32'h7fff_ffff, 32'h0, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{5'b00101, 5'b00000, 5'd3,  32'h0, 32'h0, 32'h12, 1'b0, 1'b0, 1'b1,
                     1'b1, EN ? 5'd30 : 5'd3, EN ? 32'h2 : 32'h12, 32'h0, 1'b1, 1'b0, 32'h0};
        vecs[4]  = '{5'b00111, 5'b00000, 5'd5,  32'h0, 32'hdead_beef, 32'h100, 1'b0, 1'b0, 1'b1,
                     1'b1, 5'd5, 32'h100, 32'hdead_beef, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{5'b01000, 5'b00000, 5'd8,  32'h0, 32'h55, 32'h200, 1'b0, 1'b0, 1'b0,
                     1'b1, 5'd8, 32'h200, 32'h0, 1'b1, 1'b0, 32'h0};
        vecs[6]  = '{5'b00010, 5'b00000, 5'd6,  32'h40, 32'h0, 32'h9, 1'b1, 1'b0, 1'b0,
                     1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h40};
        vecs[7]  = '{5'b00010, 5'b00000, 5'd6,  32'h80, 32'h0, 32'h9, 1'b0, 1'b1, 1'b0,
                     1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{5'b00110, 5'b00000, 5'd2,  32'h1234, 32'h0, 32'h1, 1'b0, 1'b1, 1'b0,
                     1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1234};
        vecs[9]  = '{5'b00110, 5'b00000, 5'd2,  32'h5678, 32'h0, 32'h1, 1'b1, 1'b0, 1'b0,
                     1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{5'b00000, 5'b00001, 5'd12, 32'h0, 32'h0, 32'hffff_fffe, 1'b0, 1'b0, 1'b0,
                     1'b1, 5'd12, 32'hffff_fffe, 32'h0, 1'b1, 1'b0, 32'h0};
        vecs[11] = '{5'b00101, 5'b00000, 5'd31, 32'h0, 32'hff, 32'h7, 1'b0, 1'b0, 1'b0,
                     1'b1, 5'd31, 32'h7, 32'h0, 1'b1, 1'b0, 32'h0};

        // Reset state
        idle();
        reset     = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        $display("transaction: reset released, in_ready=%0b", in_ready);

        // Table-driven single-instruction vectors
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            drive(1'b1, vecs[i].op, vecs[i].aluop, vecs[i].rd, vecs[i].target, vecs[i].sdata,
                  vecs[i].res, vecs[i].ne, vecs[i].lt, vecs[i].ovf);
            tick();
            idle();
            $display("transaction: vec %0d op=%05b rd=%0d -> out_valid=%0b out_rd=%0d out_result=0x%08h redirect=%0b pc=0x%08h",
                     i, vecs[i].op, vecs[i].rd, out_valid, out_rd, out_result, redirect_valid, redirect_pc);
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_out_rd", i), 32'(out_rd), 32'(vecs[i].e_rd));
            chk($sformatf("vec%0d_out_result", i), out_result, vecs[i].e_res);
            chk($sformatf("vec%0d_out_store_data", i), out_store_data, vecs[i].e_sd);
            chk($sformatf("vec%0d_out_wren", i), 32'(out_wren), 32'(vecs[i].e_wren));
            chk($sformatf("vec%0d_redirect_valid", i), 32'(redirect_valid), 32'(vecs[i].e_redir));
            chk($sformatf("vec%0d_redirect_pc", i), redirect_pc, vecs[i].e_pc);
            tick();
            chk($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
            chk($sformatf("vec%0d_pulse_end", i), 32'(redirect_valid), 32'd0);
            chk($sformatf("vec%0d_pc_cleared", i), redirect_pc, 32'd0);
        end

        // Backpressure: three back-to-back pushes with out_ready low
        @(negedge clock);
        out_ready = 1'b0;
        drive(1'b1, 5'b00000, 5'b00000, 5'd1, 32'h0, 32'h0, 32'h11, 1'b0, 1'b0, 1'b0);
        tick();
        chk("bp_ready_after1", 32'(in_ready), 32'd1);
        chk("bp_head_after1", 32'(out_rd), 32'd1);
        drive(1'b1, 5'b00000, 5'b00000, 5'd2, 32'h0, 32'h0, 32'h22, 1'b0, 1'b0, 1'b0);
        tick();
        chk("bp_ready_after2", 32'(in_ready), 32'd0);
        drive(1'b1, 5'b00000, 5'b00000, 5'd3, 32'h0, 32'h0, 32'h33, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("bp_full_ready", 32'(in_ready), 32'd0);
            chk("bp_full_valid", 32'(out_valid), 32'd1);
            chk("bp_full_rd", 32'(out_rd), 32'd1);
            chk("bp_full_result", out_result, 32'h11);
        end
        $display("transaction: fifo full, head rd=%0d, in_ready=%0b", out_rd, in_ready);
        out_ready = 1'b1;
        tick();
        chk("bp_pop1_rd", 32'(out_rd), 32'd2);
        chk("bp_pop1_result", out_result, 32'h22);
        chk("bp_pop1_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_pushpop_valid", 32'(out_valid), 32'd1);
        chk("bp_pushpop_rd", 32'(out_rd), 32'd3);
        chk("bp_pushpop_result", out_result, 32'h33);
        chk("bp_pushpop_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp_empty_valid", 32'(out_valid), 32'd0);
        chk("bp_empty_rd", 32'(out_rd), 32'd0);
        $display("transaction: backpressure sequence drained");

        // Reset with the FIFO full and an input offered the same edge
        @(negedge clock);
        out_ready = 1'b0;
        drive(1'b1, 5'b00000, 5'b00000, 5'd10, 32'h0, 32'h0, 32'hA0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'b01000, 5'b00000, 5'd11, 32'h0, 32'h0, 32'hB0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rst2_full_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 5'b00000, 5'b00000, 5'd13, 32'h0, 32'h0, 32'hC0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        out_ready = 1'b1;
        chk("rst2_out_valid", 32'(out_valid), 32'd0);
        chk("rst2_in_ready", 32'(in_ready), 32'd1);
        chk("rst2_out_rd", 32'(out_rd), 32'd0);
        chk("rst2_out_result", out_result, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst2_no_stale", 32'(out_valid), 32'd0);
        end
        $display("transaction: mid-operation reset discarded entries");

        // Taken branch offered on a reset edge produces no redirect
        @(negedge clock);
        drive(1'b1, 5'b00010, 5'b00000, 5'd0, 32'h99, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        chk("rst3_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst3_redirect_pc", redirect_pc, 32'd0);
        chk("rst3_out_valid", 32'(out_valid), 32'd0);
        $display("transaction: branch during reset ignored");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
